mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage, beside the 32-bit ALU datapath; consumes the same rs/rt operand buses.
- Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Implements MTHI/MTLO writes.
- The pipeline controller stalls on busy and reads HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state.
start  input  1  launch the operation selected by op; sampled only in IDLE.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  input  WIDTH  rs operand: multiplicand or dividend.
b  input  WIDTH  rt operand: multiplier or divisor.
wr_hi  input  1  MTHI: hi <= wdata.
wr_lo  input  1  MTLO: lo <= wdata.
wdata  input  WIDTH  data for MTHI/MTLO.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when HI/LO take a new result.
div_zero  output  1  pulses with done when a DIV/DIVU divisor was 0.

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately; no partial result reaches HI/LO.
- State machine: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - On start=1, latch op, |a| and |b| into working registers; latch the result sign flags; go to RUN with counter=0.
  - Absolute values are taken only for signed ops (op[0]=1).
  - MULT result sign = a[msb]^b[msb].
  - DIV quotient sign = a^b sign; DIV remainder sign = sign of a.
- RUN (exactly WIDTH cycles), one bit per cycle; exit to FIX when counter==WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract. Keep the trial difference if non-negative and set the quotient bit; else restore.
- FIX (1 cycle): two's-complement negate product / quotient / remainder per the latched sign flags.
- DONE (1 cycle): write the result, assert done, then return to IDLE.
  - Multiply result: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide result: lo=quotient, hi=remainder.
- Latency: start accepted at edge 0; busy=1 from edge 1; done=1 and HI/LO valid after edge WIDTH+2 (34 for WIDTH=32). busy drops in that same cycle.
- start while busy: ignored; no queueing.
- Divide by zero: no iteration shortcut; the full latency still applies.
  - lo = all ones; hi = a (original, unsigned view); div_zero=1 with done.
  - Sign fixing is skipped.
- Signed overflow: DIV of the most-negative value by -1 gives lo=0x80000000, hi=0 (natural wrap). No flag.
- MTHI/MTLO:
  - Effective only in IDLE; ignored while busy.
  - wr_hi and wr_lo in the same cycle both apply.
  - A write in the same cycle as start takes effect; the later result overwrites it.
- Outputs are registered; hi/lo never change except on a DONE write, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package holds the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the FSM state encoding (IDLE, RUN, FIX, DONE), so decode logic and the testbench share them.
- One sub-module: addsub_nbit, a WIDTH-bit adder/subtractor with carry out.
  - Used for multiply accumulate, trial subtract and FIX negation.
  - Takes a sub control that inverts b and forces carry-in to 1.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 for exactly one cycle with done.
- MULTU 6*7 started, then start pulsed at cycle 10 with DIVU and wr_lo=1 wdata=0xAA at cycle 12 -> both ignored; result hi=0, lo=42.
- MTHI 0x55 in IDLE, then reset asserted at cycle 20 of a DIV -> all outputs 0 immediately. Next MULTU 2*3 -> lo=6 at full latency.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mul_div_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_if.sv
// Operand/command and HI/LO result bundle between the EX stage and the mul/div unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/addsub_nbit.sv
// WIDTH-bit adder/subtractor; sub inverts b and forces the carry-in high.
module addsub_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] b_eff;
  logic             c_in;

  assign b_eff = sub ? ~b : b;
  assign c_in  = sub | cin;
  assign {cout, sum} = SW'(a) + SW'(b_eff) + SW'(c_in);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit producing architectural HI/LO, plus MTHI/MTLO writes.
// One result bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  mul_div_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 div_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     opb_q;
  logic [WIDTH-1:0]     a_raw_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dz_out_q;

  logic [WIDTH-1:0]     lo_a, lo_b, lo_sum;
  logic                 lo_sub, lo_cin, lo_cout;
  logic [WIDTH-1:0]     hi_a, hi_b, hi_sum;
  logic                 hi_sub, hi_cin, hi_cout;

  op_e                  op_in;
  logic                 in_signed;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH-1:0]     prod_hi, prod_lo, div_shift;
  logic                 trial_ok;

  assign op_in     = op_e'(bus.op);
  assign in_signed = op_is_signed(op_in);
  assign prod_hi   = prod_q[2*WIDTH-1:WIDTH];
  assign prod_lo   = prod_q[WIDTH-1:0];
  assign div_shift = {prod_hi[WIDTH-2:0], prod_lo[WIDTH-1]};
  // The bit shifted out of the partial remainder makes the trial non-negative on its own.
  assign trial_ok  = prod_hi[WIDTH-1] | lo_cout;
  assign a_abs     = (in_signed && bus.a[WIDTH-1]) ? lo_sum : bus.a;
  assign b_abs     = (in_signed && bus.b[WIDTH-1]) ? hi_sum : bus.b;

  addsub_nbit #(.WIDTH(WIDTH)) u_lo (
    .a(lo_a), .b(lo_b), .sub(lo_sub), .cin(lo_cin), .sum(lo_sum), .cout(lo_cout)
  );

  addsub_nbit #(.WIDTH(WIDTH)) u_hi (
    .a(hi_a), .b(hi_b), .sub(hi_sub), .cin(hi_cin), .sum(hi_sum), .cout(hi_cout)
  );

  // Adder steering: operand negation in IDLE, iteration in RUN, sign fix in FIX.
  always_comb begin
    lo_a   = '0;
    lo_b   = '0;
    lo_sub = 1'b0;
    lo_cin = 1'b0;
    hi_a   = '0;
    hi_b   = '0;
    hi_sub = 1'b0;
    hi_cin = 1'b0;
    case (state_q)
      IDLE: begin
        lo_b   = bus.a;
        lo_sub = 1'b1;
        hi_b   = bus.b;
        hi_sub = 1'b1;
      end
      RUN: begin
        if (div_q) begin
          lo_a   = div_shift;
          lo_b   = opb_q;
          lo_sub = 1'b1;
        end else begin
          hi_a = prod_hi;
          hi_b = prod_lo[0] ? opb_q : '0;
        end
      end
      FIX: begin
        lo_b   = prod_lo;
        lo_sub = 1'b1;
        if (div_q) begin
          hi_b   = prod_hi;
          hi_sub = 1'b1;
        end else begin
          hi_b   = ~prod_hi;
          hi_cin = lo_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      prod_q   <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      busy_q   <= (state_q == RUN) || (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wdata;
          if (bus.wr_lo) lo_q <= bus.wdata;
          if (bus.start) begin
            cnt_q   <= '0;
            div_q   <= op_is_div(op_in);
            prod_q  <= {{WIDTH{1'b0}}, a_abs};
            opb_q   <= b_abs;
            a_raw_q <= bus.a;
            neg_q_q <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_q <= in_signed & bus.a[WIDTH-1];
            dz_q    <= op_is_div(op_in) & (bus.b == '0);
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (div_q) prod_q <= {trial_ok ? lo_sum : div_shift, prod_lo[WIDTH-2:0], trial_ok};
          else       prod_q <= {hi_cout, hi_sum, prod_lo[WIDTH-1:1]};
        end
        FIX: begin
          if (!div_q) begin
            if (neg_q_q) prod_q <= {hi_sum, lo_sum};
          end else if (!dz_q) begin
            if (neg_q_q) prod_q[WIDTH-1:0]       <= lo_sum;
            if (neg_r_q) prod_q[2*WIDTH-1:WIDTH] <= hi_sum;
          end
        end
        DONE: begin
          hi_q     <= dz_q ? a_raw_q : prod_hi;
          lo_q     <= prod_lo;
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_out_q;

endmodule
